// File: rtl/data_mem_responder.sv
// Load/store responder for an RV32I core: single-port word memory with byte enables,
// request validation and a three-state handshake FSM (IDLE -> [READ] -> RESP).
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t          state_reg;
    logic [AW-1:0]   idx_reg;
    logic [1:0]      lane_reg;
    logic [2:0]      funct3_reg;
    logic            is_load_reg;
    logic            resp_valid_reg;
    logic            resp_err_reg;
    logic [31:0]     rd_word_reg;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [29:0]     word_off;
    logic [AW-1:0]   idx;
    logic            range_err;
    logic            misalign_err;
    logic            funct3_err;
    logic            req_err;
    logic            mem_we;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [31:0]     load_data;

    assign word_off  = 30'((req_addr - BASE_ADDR) >> 2);
    assign idx       = word_off[AW-1:0];
    assign range_err = (req_addr < BASE_ADDR) || ({2'b00, word_off} >= 32'(DEPTH_WORDS));

    assign misalign_err = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    always_comb begin
        funct3_err = 1'b1;
        if (req_we)
            funct3_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            funct3_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

    assign req_err   = range_err || misalign_err || funct3_err;
    assign req_ready = (state_reg == IDLE);
    // Gated by rst_n so a request presented during reset cannot commit a write.
    assign mem_we    = rst_n && req_valid && req_ready && req_we && !req_err;

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = 32'h0;
        case (req_funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = 4'b0011 << req_addr[1:0];
                wr_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_data = req_wdata;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_data = 32'h0;
            end
        endcase
    end

    // Memory port: byte-enabled write at the handshake, registered read in READ.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b])
                    mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        if (state_reg == READ)
            rd_word_reg <= mem[idx_reg];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            lane_reg       <= 2'b00;
            funct3_reg     <= 3'b000;
            is_load_reg    <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        idx_reg      <= idx;
                        lane_reg     <= req_addr[1:0];
                        funct3_reg   <= req_funct3;
                        is_load_reg  <= !req_we;
                        resp_err_reg <= req_err;
                        if (req_err || req_we) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_err_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign byte_sel = rd_word_reg[{lane_reg, 3'b000} +: 8];
    assign half_sel = lane_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];

    always_comb begin
        load_data = 32'h0;
        case (funct3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = rd_word_reg;
            3'b100:  load_data = {24'h0, byte_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase
    end

    // rd_word_reg only changes in READ, so the load result holds steady through RESP.
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = (resp_valid_reg && is_load_reg && !resp_err_reg) ? load_data : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver pushes expected responses,
// a negedge monitor pops and compares data, error flag and response latency.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   seen_first = 1'b0;

    data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every cycle a response is shown, pops on the accepting cycle.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'h0);
            end else begin
                if (!seen_first) begin
                    chk("latency", 32'(cyc), 32'(sb[0].due));
                    seen_first = 1'b1;
                end
                chk("rdata", resp_rdata, sb[0].rdata);
                chk("err", 32'(resp_err), 32'(sb[0].err));
                chk("req_ready_busy", 32'(req_ready), 32'h0);
                if (resp_ready) begin
                    $display("resp rdata=%h err=%b cycle=%0d", resp_rdata, resp_err, cyc);
                    void'(sb.pop_front());
                    seen_first = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wdata;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_wait", 32'(req_ready), 32'h1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.due   = cyc + ((we || exp_err) ? 1 : 2);
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        rst_n = 1'b1;

        // Word access and byte/halfword stores with extension
        issue(1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
        issue(1, 32'h13, 3'b000, 32'h00000080, 32'h0, 0);
        issue(0, 32'h13, 3'b000, 32'h0, 32'hFFFFFF80, 0);
        issue(0, 32'h13, 3'b100, 32'h0, 32'h00000080, 0);
        issue(0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 0);
        issue(1, 32'h20, 3'b010, 32'h12345678, 32'h0, 0);
        issue(1, 32'h22, 3'b001, 32'h00008001, 32'h0, 0);
        issue(0, 32'h22, 3'b001, 32'h0, 32'hFFFF8001, 0);
        issue(0, 32'h22, 3'b101, 32'h0, 32'h00008001, 0);
        issue(0, 32'h20, 3'b010, 32'h0, 32'h80015678, 0);
        issue(0, 32'h21, 3'b000, 32'h0, 32'h00000056, 0);

        // Errors and range boundary
        issue(1, 32'h0, 3'b010, 32'hCAFEF00D, 32'h0, 0);
        issue(0, 32'h11, 3'b010, 32'h0, 32'h0, 1);
        issue(1, 32'h1000, 3'b010, 32'hFFFFFFFF, 32'h0, 1);
        issue(0, 32'h0, 3'b010, 32'h0, 32'hCAFEF00D, 0);
        issue(0, 32'h10, 3'b011, 32'h0, 32'h0, 1);
        issue(1, 32'h10, 3'b100, 32'h0, 32'h0, 1);
        issue(0, 32'h21, 3'b001, 32'h0, 32'h0, 1);
        issue(1, 32'hFFC, 3'b010, 32'h11112222, 32'h0, 0);
        issue(0, 32'hFFC, 3'b010, 32'h0, 32'h11112222, 0);
        issue(0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 0);
        drain();

        // Backpressure on a load response
        resp_ready = 1'b0;
        issue(0, 32'h20, 3'b010, 32'h0, 32'h80015678, 0);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp_valid", 32'(resp_valid), 32'h1);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_req_ready", 32'(req_ready), 32'h1);
        chk("bp_release_resp_valid", 32'(resp_valid), 32'h0);
        drain();

        // Reset while in READ
        issue(0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'h1);
        chk("midrst_resp_rdata", resp_rdata, 32'h0);
        sb.delete();
        seen_first = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_hold_valid", 32'(resp_valid), 32'h0);
        rst_n = 1'b1;
        issue(0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 0);
        issue(0, 32'h22, 3'b001, 32'h0, 32'hFFFF8001, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in the internal memory array.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 The block SHALL run on one clock, clk; reset rst_n SHALL be asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  the CPU is presenting a load/store request.
REQ-007 req_ready  out  1  the responder can accept a request this cycle.
REQ-008 req_we  in  1  1 = STORE, 0 = LOAD.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_funct3  in  3  RV32I width code: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-011 req_wdata  in  32  store data, right-aligned (rs2 value).
REQ-012 resp_valid  out  1  a response is available.
REQ-013 resp_ready  in  1  the CPU accepts the response.
REQ-014 resp_rdata  out  32  load result, already extended; 0 for stores and for errors.
REQ-015 resp_err  out  1  the request was misaligned, out of range or had an illegal funct3.

Function
REQ-016 The FSM SHALL have three states: IDLE, READ and RESP; req_ready=1 only in IDLE.
REQ-017 A handshake SHALL occur when req_valid=1 and req_ready=1 in the same cycle; all request fields SHALL be captured at that edge.
REQ-018 A request SHALL be checked for errors as follows; an erroring request SHALL go IDLE->RESP with resp_err=1, resp_rdata=0 and no memory write.
- Range: word index (req_addr-BASE_ADDR)>>2 >= DEPTH_WORDS, or req_addr < BASE_ADDR.
- Misalignment: halfword access with addr[0]=1, or word access with addr[1:0]!=0.
- Illegal funct3: any load code outside {000,001,010,100,101}, or any store code outside {000,001,010}.
REQ-019 A legal store SHALL write at the handshake edge using byte enables:
- SB: 4'b0001<<addr[1:0], data byte replicated on all lanes.
- SH: 4'b0011<<addr[1:0], data halfword replicated on both halves.
- SW: 4'b1111.
REQ-020 A legal store SHALL then go IDLE->RESP, so resp_valid is high one cycle after the handshake.
REQ-021 A legal load SHALL go IDLE->READ->RESP, performing a registered array read in READ, so resp_valid is high two cycles after the handshake.
REQ-022 Load data SHALL be formed as follows:
- Byte select by addr[1:0]; halfword select by addr[1].
- LB and LH sign-extend the selected data; LBU and LHU zero-extend it; LW passes the word unchanged.
REQ-023 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1, then the FSM SHALL return to IDLE on that edge.
REQ-024 No request SHALL be accepted in the cycle a response completes; the earliest next handshake is the following cycle in IDLE.
REQ-025 With resp_ready held at 1, throughput SHALL be one store per 2 cycles and one load per 3 cycles.
REQ-026 The memory array SHALL be single-port; a load following a store to the same word SHALL return the stored data.

Reset
REQ-027 While rst_n=0, the FSM SHALL be IDLE, req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset asserted mid-operation SHALL drop any pending response.
REQ-030 A store whose handshake edge completed before reset SHALL remain committed.

Verification
REQ-031 Word access: SW 32'hDEADBEEF to 0x10, then LW from 0x10 -> resp_rdata=32'hDEADBEEF, resp_err=0, resp_valid exactly 2 cycles after the LW handshake.
REQ-032 Byte store and extension: after REQ-031, SB 8'h80 to 0x13, then LB from 0x13 -> 32'hFFFFFF80; LBU from 0x13 -> 32'h00000080; LW from 0x10 -> 32'h80ADBEEF.
REQ-033 Halfword extension: SH 16'h8001 to 0x22, then LH from 0x22 -> 32'hFFFF8001; LHU from 0x22 -> 32'h00008001; LW from 0x20 -> upper half 16'h8001, lower half unchanged.
REQ-034 Errors: LW from 0x11 -> resp_err=1, resp_rdata=0; SW to 0x1000 with DEPTH_WORDS=1024 -> resp_err=1 and no memory word changes; load with funct3=011 -> resp_err=1.
REQ-035 Backpressure: hold resp_ready=0 for 5 cycles on a load response -> resp_valid and resp_rdata stay stable and req_ready=0 throughout; req_ready=1 the cycle after resp_ready=1.
REQ-036 Reset mid-load: assert rst_n=0 while in READ -> resp_valid=0 and req_ready=1 immediately; the prior stored data is still readable after reset.
